// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if
// Handshake and result bundle between a stream decoder and its host.
//   master : host side. Drives start, bit_valid, bit_in, ref_bit and out_ready.
//            Observes the result and status outputs.
//   slave  : decoder side, the mirror image of master.
// CNT_W sets the counter width. It must match the decoder's CNT_W.
interface sc_stream_decoder_if #(
  parameter int CNT_W = 8
);
  logic                    start;
  logic                    bit_valid;
  logic                    bit_in;
  logic                    ref_bit;
  logic                    out_ready;
  logic                    out_valid;
  logic [CNT_W-1:0]        ones_count;
  logic signed [CNT_W:0]   bipolar_val;
  logic [CNT_W-1:0]        ref_count;
  logic [CNT_W-1:0]        mismatch_cnt;
  logic                    alarm;
  logic                    overrun;
  logic                    busy;

  modport master (
    output start, bit_valid, bit_in, ref_bit, out_ready,
    input  out_valid, ones_count, bipolar_val, ref_count, mismatch_cnt,
           alarm, overrun, busy
  );

  modport slave (
    input  start, bit_valid, bit_in, ref_bit, out_ready,
    output out_valid, ones_count, bipolar_val, ref_count, mismatch_cnt,
           alarm, overrun, busy
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
// Decodes one window of a stochastic bitstream.
// It accepts BIT_LENGTH bits, one per clock when bit_valid is high.
// It reports the ones-count and the bipolar value 2*ones - BIT_LENGTH.
// The result is presented over a valid/ready handshake.
//
// Ports:
//   clk    : clock, rising edge.
//   rst_n  : asynchronous active-low reset.
//   io_bus : sc_stream_decoder_if.slave.
//            Inputs:  start, bit_valid, bit_in, ref_bit, out_ready.
//            Outputs: out_valid, ones_count, bipolar_val, ref_count,
//                     mismatch_cnt, alarm, overrun, busy.
//
// Optional feature, macro SC_DECODER_TROJAN_CHECK_EN:
//   When defined, the reference stream and the mismatch count are also
//   accumulated. alarm flags |ones - ref| >= ALARM_THRESHOLD.
//   When undefined, ref_count, mismatch_cnt and alarm read as 0.
module sc_stream_decoder #(
  parameter int BIT_LENGTH      = 128,
  parameter int CNT_W           = 8,
  parameter int ALARM_THRESHOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sc_stream_decoder_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST_IDX = CNT_W'(BIT_LENGTH - 1);
  localparam logic [CNT_W:0]   LP_LEN_EXT  = (CNT_W + 1)'(BIT_LENGTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clear;     // accepted start: wipe counters, new window
  logic             w_accept;    // a stream bit is counted this cycle
  logic             w_last;      // accepted bit is the final one of the window
  logic             w_set_ovr;   // bit arrived while a result is pending

  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] w_ones_nxt;
  logic [CNT_W:0]   r_bipolar;
  logic [CNT_W:0]   w_bipolar_nxt;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overrun;

  // Next-state and control decode for the window FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // An abort outranks a bit in the same cycle; that bit is dropped.
        if (io_bus.start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_ACCUM;
        end else if (io_bus.bit_valid) begin
          w_accept = 1'b1;
          if (r_idx == LP_LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: begin
        w_set_ovr = io_bus.bit_valid;
        if (io_bus.out_ready) begin
          // A start that coincides with the handshake chains straight into a new window.
          if (io_bus.start) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_ACCUM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Count of ones including the bit accepted this cycle.
  always_comb begin
    w_ones_nxt = r_ones + CNT_W'(io_bus.bit_in);
  end

  // Bipolar value: true value fits CNT_W+1 bits, so modular arithmetic is exact.
  always_comb begin
    w_bipolar_nxt = {w_ones_nxt, 1'b0} - LP_LEN_EXT;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_ACCUM);
    end
  end

  // Bit index and ones counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= {CNT_W{1'b0}};
      r_ones <= {CNT_W{1'b0}};
    end else if (w_clear) begin
      r_idx  <= {CNT_W{1'b0}};
      r_ones <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_idx  <= r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
      r_ones <= w_ones_nxt;
    end else begin
      r_idx  <= r_idx;
      r_ones <= r_ones;
    end
  end

  // Bipolar result, captured as the window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bipolar <= {(CNT_W+1){1'b0}};
    end else if (w_last) begin
      r_bipolar <= w_bipolar_nxt;
    end else begin
      r_bipolar <= r_bipolar;
    end
  end

  // Sticky overrun flag; a new window clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_clear) begin
      r_overrun <= 1'b0;
    end else if (w_set_ovr) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

`ifdef SC_DECODER_TROJAN_CHECK_EN
  logic [CNT_W-1:0] r_ref;
  logic [CNT_W-1:0] r_mis;
  logic             r_alarm;
  logic [CNT_W-1:0] w_ref_nxt;
  logic [CNT_W-1:0] w_mis_nxt;
  logic [CNT_W-1:0] w_diff;

  // Reference and mismatch counts including this cycle's bit, and |ones - ref|.
  always_comb begin
    w_ref_nxt = r_ref + CNT_W'(io_bus.ref_bit);
    w_mis_nxt = r_mis + CNT_W'(io_bus.bit_in ^ io_bus.ref_bit);
    if (w_ones_nxt >= w_ref_nxt) begin
      w_diff = w_ones_nxt - w_ref_nxt;
    end else begin
      w_diff = w_ref_nxt - w_ones_nxt;
    end
  end

  // Reference and mismatch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= {CNT_W{1'b0}};
      r_mis <= {CNT_W{1'b0}};
    end else if (w_clear) begin
      r_ref <= {CNT_W{1'b0}};
      r_mis <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_ref <= w_ref_nxt;
      r_mis <= w_mis_nxt;
    end else begin
      r_ref <= r_ref;
      r_mis <= r_mis;
    end
  end

  // Deviation alarm, captured as the window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (w_last) begin
      r_alarm <= (w_diff >= CNT_W'(ALARM_THRESHOLD));
    end else begin
      r_alarm <= r_alarm;
    end
  end

  assign io_bus.ref_count    = r_ref;
  assign io_bus.mismatch_cnt = r_mis;
  assign io_bus.alarm        = r_alarm;
`else
  // Reference stream and threshold have no function without the check.
  logic w_unused_ref;
  assign w_unused_ref        = io_bus.ref_bit ^ (ALARM_THRESHOLD < 32'sd1);
  assign io_bus.ref_count    = {CNT_W{1'b0}};
  assign io_bus.mismatch_cnt = {CNT_W{1'b0}};
  assign io_bus.alarm        = 1'b0;
`endif

  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.busy        = r_busy;
  assign io_bus.overrun     = r_overrun;
  assign io_bus.ones_count  = r_ones;
  assign io_bus.bipolar_val = r_bipolar;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder
// Self-checking bench for sc_stream_decoder.
// Directed windows come from a table. The multi-cycle corners are hand-written
// sequences. Random windows are checked against a counting model.
// Expected trojan-check outputs follow SC_DECODER_TROJAN_CHECK_EN.
module tb_sc_stream_decoder;
  localparam int BL  = 128;
  localparam int CW  = 8;
  localparam int THR = 4;
`ifdef SC_DECODER_TROJAN_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    int ones;
    int bip;
    int refc;
    int mis;
    int alarm;
  } res_t;

  typedef struct {
    logic [BL-1:0] bits;
    logic [BL-1:0] refs;
    int            stall;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sc_stream_decoder_if #(.CNT_W(CW)) dif ();

  sc_stream_decoder #(
    .BIT_LENGTH(BL), .CNT_W(CW), .ALARM_THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(dif)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference counts computed straight from the window contents.
  function automatic res_t model(input logic [BL-1:0] b, input logic [BL-1:0] r);
    res_t m;
    m.ones = 0; m.refc = 0; m.mis = 0;
    for (int i = 0; i < BL; i++) begin
      m.ones += int'(b[i]);
      m.refc += int'(r[i]);
      m.mis  += (b[i] != r[i]) ? 1 : 0;
    end
    m.bip   = 2 * m.ones - BL;
    m.alarm = (((m.ones > m.refc) ? (m.ones - m.refc) : (m.refc - m.ones)) >= THR) ? 1 : 0;
    if (!FEAT) begin
      m.refc = 0; m.mis = 0; m.alarm = 0;
    end
    return m;
  endfunction

  function automatic res_t mask(input res_t e);
    res_t m = e;
    if (!FEAT) begin
      m.refc = 0; m.mis = 0; m.alarm = 0;
    end
    return m;
  endfunction

  task automatic chk_zero(input string p);
    chk({p, "_out_valid"}, 32'(dif.out_valid), 0);
    chk({p, "_busy"}, 32'(dif.busy), 0);
    chk({p, "_ones"}, 32'(dif.ones_count), 0);
    chk({p, "_bip"}, 32'($signed(dif.bipolar_val)), 0);
    chk({p, "_ref"}, 32'(dif.ref_count), 0);
    chk({p, "_mis"}, 32'(dif.mismatch_cnt), 0);
    chk({p, "_alarm"}, 32'(dif.alarm), 0);
    chk({p, "_overrun"}, 32'(dif.overrun), 0);
  endtask

  task automatic chk_res(input string p, input res_t e);
    chk({p, "_out_valid"}, 32'(dif.out_valid), 1);
    chk({p, "_busy"}, 32'(dif.busy), 0);
    chk({p, "_ones"}, 32'(dif.ones_count), e.ones);
    chk({p, "_bip"}, 32'($signed(dif.bipolar_val)), e.bip);
    chk({p, "_ref"}, 32'(dif.ref_count), e.refc);
    chk({p, "_mis"}, 32'(dif.mismatch_cnt), e.mis);
    chk({p, "_alarm"}, 32'(dif.alarm), e.alarm);
  endtask

  task automatic do_start();
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // stall: 0 none, 1 every third cycle idle, 2 random idles. Garbage is driven on idle cycles.
  task automatic feed(input string p, input logic [BL-1:0] bits, input logic [BL-1:0] refs, input int stall);
    int i = 0;
    int cyc = 0;
    bit early = 1'b0;
    while (i < BL && cyc < 4 * BL) begin
      if (dif.out_valid !== 1'b0 || dif.busy !== 1'b1) early = 1'b1;
      if ((stall == 1 && cyc % 3 == 2) || (stall == 2 && $urandom_range(3, 0) == 0)) begin
        dif.bit_valid = 1'b0;
        dif.bit_in    = 1'($urandom_range(1, 0));
        dif.ref_bit   = 1'($urandom_range(1, 0));
      end else begin
        dif.bit_valid = 1'b1;
        dif.bit_in    = bits[i];
        dif.ref_bit   = refs[i];
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    dif.bit_valid = 1'b0;
    chk({p, "_fed_all"}, i, BL);
    chk({p, "_no_early_valid"}, 32'(early), 0);
  endtask

  task automatic handshake(input string p, input int held_ones);
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    chk({p, "_valid_drop"}, 32'(dif.out_valid), 0);
    chk({p, "_ones_held"}, 32'(dif.ones_count), held_ones);
  endtask

  vec_t          tbl[6];
  logic [BL-1:0] t;
  logic [BL-1:0] rb;
  logic [BL-1:0] rr;
  res_t          e;
  bit            bad;

  initial begin
    dif.start = 1'b0; dif.bit_valid = 1'b0; dif.bit_in = 1'b0;
    dif.ref_bit = 1'b0; dif.out_ready = 1'b0;
    rst_n = 1'b0;

    tbl[0] = '{{BL{1'b1}}, {BL{1'b1}}, 0, '{128, 128, 128, 0, 0}};
    tbl[1] = '{{64{2'b01}}, {64{2'b01}}, 1, '{64, 0, 64, 0, 0}};
    tbl[2] = '{{BL{1'b0}}, {BL{1'b0}}, 0, '{0, -128, 0, 0, 0}};
    tbl[3] = '{{{64{1'b0}}, {64{1'b1}}}, {BL{1'b1}}, 0, '{64, 0, 128, 64, 1}};
    t = {BL{1'b1}}; t[5] = 1'b0; t[70] = 1'b0; t[127] = 1'b0;
    tbl[4] = '{t, {BL{1'b1}}, 1, '{125, 122, 128, 3, 0}};
    t[0] = 1'b0;
    tbl[5] = '{t, {BL{1'b1}}, 0, '{124, 120, 128, 4, 1}};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    for (int k = 0; k < 6; k++) begin
      do_start();
      feed($sformatf("tbl%0d", k), tbl[k].bits, tbl[k].refs, tbl[k].stall);
      chk_res($sformatf("tbl%0d", k), mask(tbl[k].exp));
      handshake($sformatf("tbl%0d", k), tbl[k].exp.ones);
    end

    // Bits in IDLE are ignored and do not raise overrun.
    dif.bit_valid = 1'b1; dif.bit_in = 1'b1;
    repeat (2) @(negedge clk);
    dif.bit_valid = 1'b0;
    chk("idle_bits_busy", 32'(dif.busy), 0);
    chk("idle_bits_ones", 32'(dif.ones_count), 124);
    chk("idle_bits_overrun", 32'(dif.overrun), 0);

    // Backpressure with overrun.
    do_start();
    feed("bp", {BL{1'b1}}, {BL{1'b1}}, 0);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      dif.bit_valid = (c % 3 == 0);
      dif.bit_in    = 1'b0;
      @(negedge clk);
      if (dif.out_valid !== 1'b1 || dif.ones_count !== 8'd128 ||
          $signed(dif.bipolar_val) !== 9'sd128) bad = 1'b1;
    end
    dif.bit_valid = 1'b0;
    chk("bp_stable", 32'(bad), 0);
    chk("bp_overrun_set", 32'(dif.overrun), 1);
    handshake("bp", 128);
    chk("bp_idle_busy", 32'(dif.busy), 0);
    chk("bp_overrun_sticky", 32'(dif.overrun), 1);
    do_start();
    chk("bp_overrun_cleared", 32'(dif.overrun), 0);

    // Abort at bit 50: the bit sent together with start must be discarded.
    for (int i = 0; i < 50; i++) begin
      dif.bit_valid = 1'b1; dif.bit_in = 1'b1; dif.ref_bit = 1'b1;
      @(negedge clk);
    end
    chk("abort_pre_ones", 32'(dif.ones_count), 50);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.bit_valid = 1'b0;
    chk("abort_cleared", 32'(dif.ones_count), 0);
    chk("abort_busy", 32'(dif.busy), 1);
    feed("abort", {BL{1'b0}}, {BL{1'b0}}, 0);
    chk_res("abort", mask('{0, -128, 0, 0, 0}));
    handshake("abort", 0);

    // In DONE, start without ready is ignored; start with ready chains into a new window.
    do_start();
    feed("chain", {BL{1'b1}}, {BL{1'b1}}, 0);
    dif.start = 1'b1; dif.out_ready = 1'b0;
    @(negedge clk);
    chk("start_noready_valid", 32'(dif.out_valid), 1);
    chk("start_noready_busy", 32'(dif.busy), 0);
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.out_ready = 1'b0;
    chk("chain_valid", 32'(dif.out_valid), 0);
    chk("chain_busy", 32'(dif.busy), 1);
    chk("chain_ones", 32'(dif.ones_count), 0);
    for (int i = 0; i < BL; i++) rb[i] = 1'($urandom_range(1, 0));
    feed("chain_rnd", rb, rb, 2);
    chk_res("chain_rnd", model(rb, rb));
    handshake("chain_rnd", model(rb, rb).ones);

    // Asynchronous reset partway through a window.
    do_start();
    for (int i = 0; i < 30; i++) begin
      dif.bit_valid = 1'b1; dif.bit_in = 1'b1; dif.ref_bit = 1'b0;
      @(negedge clk);
    end
    dif.bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");

    // Random windows against the model, with random stalls and backpressure.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < BL; i++) begin
        rb[i] = 1'($urandom_range(1, 0));
        if (r % 2 == 0) rr[i] = rb[i] ^ ($urandom_range(15, 0) == 0);
        else            rr[i] = 1'($urandom_range(1, 0));
      end
      e = model(rb, rr);
      do_start();
      feed($sformatf("rnd%0d", r), rb, rr, 2);
      bad = 1'b0;
      repeat ($urandom_range(5, 0)) begin
        @(negedge clk);
        if (dif.out_valid !== 1'b1 || 32'(dif.ones_count) !== e.ones) bad = 1'b1;
      end
      chk($sformatf("rnd%0d_hold", r), 32'(bad), 0);
      chk_res($sformatf("rnd%0d", r), e);
      handshake($sformatf("rnd%0d", r), e.ones);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
